// File: rtl/io_output_bank.sv
// -----------------------------------------------------------------------------
// io_output_bank
//
// Memory-mapped bank of NPORTS output registers, W bits each, on the CPU IO
// bus at byte addresses 0x80-0xFF. Each port can be written through four
// aliases:
//   0x80+4p  DATA  port = (port & ~bm) | (d & bm)
//   0xA0+4p  SET   port = port |  (d & bm)
//   0xC0+4p  CLR   port = port & ~(d & bm)
//   0xE0+4p  TGL   port = port ^  (d & bm)
// where bm is the byte mask expanded from be and d = datas[W-1:0].
// Reads through any alias return the current port value, registered, with a
// one-cycle rvalid strobe. Ports selected by PULSE_MASK fall back to 0 exactly
// PULSE_LEN cycles after their most recent write.
//
// Ports:
//   io_clk           IO clock, rising edge
//   clrn             asynchronous active-low reset
//   addr[31:0]       byte address, only addr[7:0] decoded (addr[1:0] ignored)
//   datas[31:0]      write data, bits above W ignored
//   be[3:0]          byte enables, be[k] qualifies datas[8k+7:8k]
//   write_io_enable  write strobe, one write per cycle
//   read_io_enable   read strobe
//   out_ports        port i at bits [i*W+W-1 : i*W]
//   rdata[31:0]      readback data, zero-extended, 0 when rvalid is low
//   rvalid           one-cycle strobe, high the cycle after a block-hit read
//   pulse_active     bit i high while port i's pulse counter is nonzero
// -----------------------------------------------------------------------------
module io_output_bank #(
  parameter int unsigned NPORTS     = 2,
  parameter int unsigned W          = 32,
  parameter logic [31:0] RESET_VAL  = 32'h0,
  parameter logic [7:0]  PULSE_MASK = 8'h0,
  parameter int unsigned PULSE_LEN  = 16
) (
  input  logic                  io_clk,
  input  logic                  clrn,
  input  logic [31:0]           addr,
  input  logic [31:0]           datas,
  input  logic [3:0]            be,
  input  logic                  write_io_enable,
  input  logic                  read_io_enable,
  output logic [NPORTS*W-1:0]   out_ports,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic [NPORTS-1:0]     pulse_active
);

  typedef enum logic [1:0] {
    OP_DATA = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_TGL  = 2'b11
  } op_t;

  localparam logic [15:0]  PULSE_LEN_16 = 16'(PULSE_LEN);
  localparam logic [3:0]   NPORTS_4     = 4'(NPORTS);
  localparam logic [W-1:0] RESET_W      = RESET_VAL[W-1:0];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       blk_hit;
  op_t        op;
  logic [2:0] port_idx;
  logic       idx_ok;

  assign blk_hit  = addr[7];
  assign op       = op_t'(addr[6:5]);
  assign port_idx = addr[4:2];
  assign idx_ok   = ({1'b0, port_idx} < NPORTS_4);

  // ---------------------------------------------------------------------------
  // Byte mask and masked write data, shared by every port
  // ---------------------------------------------------------------------------
  logic [31:0]  bm_full;
  logic [W-1:0] bm;
  logic [W-1:0] dm;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bm
      assign bm_full[gi*8 +: 8] = {8{be[gi]}};
    end
  endgenerate

  assign bm = bm_full[W-1:0];
  assign dm = datas[W-1:0] & bm;

  // Address bits outside the decode and data bits above W are intentionally
  // not used; folding them here keeps that explicit.
  logic unused_bits;
  assign unused_bits = ^{addr[31:8], addr[1:0], datas, bm_full};

  // ---------------------------------------------------------------------------
  // Per-port register and pulse counter
  // ---------------------------------------------------------------------------
  logic [NPORTS*W-1:0] ports_flat;

  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      localparam logic [2:0] IDX = 3'(gi);
      // A port only pulses when it is selected and the length is nonzero;
      // otherwise its counter never leaves 0 and folds away.
      localparam bit PULSED = PULSE_MASK[gi] && (PULSE_LEN != 0);

      logic [W-1:0] port_reg;
      logic [W-1:0] port_next;
      logic [W-1:0] upd_val;
      logic [15:0]  cnt_reg;
      logic [15:0]  cnt_next;
      logic         wr_hit;

      assign wr_hit = write_io_enable && blk_hit && (port_idx == IDX);

      always_comb begin
        upd_val = port_reg;
        case (op)
          OP_DATA: upd_val = (port_reg & ~bm) | dm;
          OP_SET:  upd_val = port_reg | dm;
          OP_CLR:  upd_val = port_reg & ~dm;
          OP_TGL:  upd_val = port_reg ^ dm;
          default: upd_val = port_reg;
        endcase
      end

      // A write always wins over expiry: it applies the new value and
      // restarts the count, so a write landing on the 1->0 cycle never sees
      // the clear. be=0 still reloads the counter.
      always_comb begin
        port_next = port_reg;
        cnt_next  = cnt_reg;
        if (wr_hit) begin
          port_next = upd_val;
          if (PULSED) begin
            cnt_next = PULSE_LEN_16;
          end
        end else if (cnt_reg != 16'd0) begin
          cnt_next = cnt_reg - 16'd1;
          if (cnt_reg == 16'd1) begin
            port_next = '0;
          end
        end
      end

      always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
          port_reg <= RESET_W;
          cnt_reg  <= 16'd0;
        end else begin
          port_reg <= port_next;
          cnt_reg  <= cnt_next;
        end
      end

      assign ports_flat[gi*W +: W] = port_reg;
      assign pulse_active[gi]      = (cnt_reg != 16'd0);
    end
  endgenerate

  assign out_ports = ports_flat;

  // ---------------------------------------------------------------------------
  // Readback: sampled from the register outputs, so a same-edge write to the
  // same port returns the old value.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_sel;
  logic [31:0] rdata_reg;
  logic        rvalid_reg;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (port_idx == 3'(i)) begin
        rd_sel[W-1:0] = ports_flat[i*W +: W];
      end
    end
  end

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= read_io_enable && blk_hit;
      rdata_reg  <= (read_io_enable && blk_hit && idx_ok) ? rd_sel : 32'h0;
    end
  end

  assign rvalid = rvalid_reg;
  assign rdata  = rdata_reg;

endmodule

// File: tb/tb_io_output_bank.sv
// -----------------------------------------------------------------------------
// Testbench for io_output_bank. Three instances share one bus:
//   A: NPORTS=2, W=32, RESET_VAL=0x5A, no pulse ports
//   B: NPORTS=2, W=32, RESET_VAL=0x5A, port 1 pulsed, PULSE_LEN=4
//   C: NPORTS=3, W=8,  RESET_VAL=0x1A5, port 0 masked but PULSE_LEN=0
// A bit-level/time-based model predicts every output and is compared on each
// falling edge; literal expectations pin key values after each transaction.
// -----------------------------------------------------------------------------
module tb_io_output_bank;

  logic        io_clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] datas = '0;
  logic [3:0]  be = '0;
  logic        write_io_enable = 1'b0;
  logic        read_io_enable = 1'b0;

  logic [63:0] out_a, out_b;
  logic [23:0] out_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic [1:0]  pa_a, pa_b;
  logic [2:0]  pa_c;

  always #5 io_clk = ~io_clk;

  io_output_bank #(.NPORTS(2), .W(32), .RESET_VAL(32'h5A), .PULSE_MASK(8'h00), .PULSE_LEN(16)) dut_a (
    .io_clk(io_clk), .clrn(clrn), .addr(addr), .datas(datas), .be(be),
    .write_io_enable(write_io_enable), .read_io_enable(read_io_enable),
    .out_ports(out_a), .rdata(rdata_a), .rvalid(rvalid_a), .pulse_active(pa_a));

  io_output_bank #(.NPORTS(2), .W(32), .RESET_VAL(32'h5A), .PULSE_MASK(8'h02), .PULSE_LEN(4)) dut_b (
    .io_clk(io_clk), .clrn(clrn), .addr(addr), .datas(datas), .be(be),
    .write_io_enable(write_io_enable), .read_io_enable(read_io_enable),
    .out_ports(out_b), .rdata(rdata_b), .rvalid(rvalid_b), .pulse_active(pa_b));

  io_output_bank #(.NPORTS(3), .W(8), .RESET_VAL(32'h1A5), .PULSE_MASK(8'h01), .PULSE_LEN(0)) dut_c (
    .io_clk(io_clk), .clrn(clrn), .addr(addr), .datas(datas), .be(be),
    .write_io_enable(write_io_enable), .read_io_enable(read_io_enable),
    .out_ports(out_c), .rdata(rdata_c), .rvalid(rvalid_c), .pulse_active(pa_c));

  int checks = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Model configuration (one entry per instance)
  // ---------------------------------------------------------------------------
  int          cfg_np   [3] = '{2, 2, 3};
  int          cfg_w    [3] = '{32, 32, 8};
  logic [31:0] cfg_rst  [3] = '{32'h5A, 32'h5A, 32'h1A5};
  logic [7:0]  cfg_mask [3] = '{8'h00, 8'h02, 8'h01};
  int          cfg_len  [3] = '{16, 4, 0};

  // Model state: port values, the edge number at which a pulse expires, and
  // the expected read response.
  logic [31:0] m_port  [3][8];
  int          m_dead  [3][8];
  logic        m_rvalid[3];
  logic [31:0] m_rdata [3];
  int          cyc = 0;
  bit          model_ok = 1'b0;
  int          mp;
  logic [31:0] v;

  function automatic bit pulsed(int c, int i);
    return cfg_mask[c][i] && (cfg_len[c] != 0);
  endfunction

  function automatic logic [31:0] exp_pa(int c);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < cfg_np[c]; i++) r[i] = (m_dead[c][i] > cyc);
    return r;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t actual=%h required=%h", nm, idx, $time, got, exp);
    end
  endtask

  // Model update: edge-numbered, bit-by-bit application of the write rules.
  initial forever begin
    @(posedge io_clk or negedge clrn);
    if (!clrn) begin
      model_ok = 1'b1;
      for (int c = 0; c < 3; c++) begin
        m_rvalid[c] = 1'b0;
        m_rdata[c]  = '0;
        for (int i = 0; i < 8; i++) begin
          m_dead[c][i] = 0;
          m_port[c][i] = '0;
          for (int b = 0; b < cfg_w[c]; b++) m_port[c][i][b] = cfg_rst[c][b];
        end
      end
    end else begin
      cyc++;
      mp = int'(addr[4:2]);
      for (int c = 0; c < 3; c++) begin
        m_rvalid[c] = read_io_enable && addr[7];
        m_rdata[c]  = (m_rvalid[c] && mp < cfg_np[c]) ? m_port[c][mp] : 32'h0;
        for (int i = 0; i < cfg_np[c]; i++) begin
          if (write_io_enable && addr[7] && mp == i) begin
            v = m_port[c][i];
            for (int b = 0; b < cfg_w[c]; b++) begin
              if (be[b/8]) begin
                case (addr[6:5])
                  2'b00:   v[b] = datas[b];
                  2'b01:   v[b] = v[b] | datas[b];
                  2'b10:   v[b] = v[b] & ~datas[b];
                  default: v[b] = v[b] ^ datas[b];
                endcase
              end
            end
            m_port[c][i] = v;
            if (pulsed(c, i)) m_dead[c][i] = cyc + cfg_len[c];
          end else if (pulsed(c, i) && cyc == m_dead[c][i]) begin
            m_port[c][i] = '0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  initial forever begin
    @(negedge io_clk);
    if (model_ok) begin
      for (int i = 0; i < 2; i++) begin
        check("a_port", i, out_a[i*32 +: 32], m_port[0][i]);
        check("b_port", i, out_b[i*32 +: 32], m_port[1][i]);
      end
      for (int i = 0; i < 3; i++) check("c_port", i, {24'h0, out_c[i*8 +: 8]}, m_port[2][i]);
      check("a_rvalid", 0, {31'h0, rvalid_a}, {31'h0, m_rvalid[0]});
      check("b_rvalid", 0, {31'h0, rvalid_b}, {31'h0, m_rvalid[1]});
      check("c_rvalid", 0, {31'h0, rvalid_c}, {31'h0, m_rvalid[2]});
      check("a_rdata", 0, rdata_a, m_rdata[0]);
      check("b_rdata", 0, rdata_b, m_rdata[1]);
      check("c_rdata", 0, rdata_c, m_rdata[2]);
      check("a_pact", 0, {30'h0, pa_a}, exp_pa(0));
      check("b_pact", 0, {30'h0, pa_b}, exp_pa(1));
      check("c_pact", 0, {29'h0, pa_c}, exp_pa(2));
    end
  end

  // Drives one bus cycle starting just after a rising edge; returns 1 time
  // unit after the edge that consumed it.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                     input logic we, input logic re);
    addr = a; datas = d; be = b; write_io_enable = we; read_io_enable = re;
    $display("txn t=%0t we=%0b re=%0b addr=%h datas=%h be=%b", $time, we, re, a, d, b);
    @(posedge io_clk); #1;
    write_io_enable = 1'b0; read_io_enable = 1'b0;
  endtask

  task automatic idle();
    @(posedge io_clk); #1;
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge io_clk);
    #1;
    check("lit_rst_a_p0", 0, out_a[31:0], 32'h5A);
    check("lit_rst_a_p1", 0, out_a[63:32], 32'h5A);
    check("lit_rst_c", 0, {8'h0, out_c}, 32'h00A5A5A5);
    check("lit_rst_rvalid", 0, {31'h0, rvalid_a}, 32'h0);
    check("lit_rst_pact", 0, {30'h0, pa_b}, 32'h0);
    clrn = 1'b1;
    repeat (5) idle();
    check("lit_idle_a_p0", 0, out_a[31:0], 32'h5A);
    check("lit_idle_b_p1", 0, out_b[63:32], 32'h5A);

    // Byte-enabled DATA writes
    bus(32'h80, 32'h0, 4'hF, 1, 0);
    bus(32'h80, 32'hAABBCCDD, 4'b0101, 1, 0);
    check("lit_be_p0", 0, out_a[31:0], 32'h00BB00DD);
    bus(32'h84, 32'h12345678, 4'hF, 1, 0);
    check("lit_data_p1", 0, out_a[63:32], 32'h12345678);
    check("lit_data_p0", 0, out_a[31:0], 32'h00BB00DD);

    // SET / CLR / TGL
    bus(32'h80, 32'h0F0F0F0F, 4'hF, 1, 0);
    bus(32'hA0, 32'hF0000000, 4'hF, 1, 0);
    check("lit_set", 0, out_a[31:0], 32'hFF0F0F0F);
    bus(32'hC0, 32'h0000000F, 4'hF, 1, 0);
    check("lit_clr", 0, out_a[31:0], 32'hFF0F0F00);
    bus(32'hE0, 32'hFFFFFFFF, 4'hF, 1, 0);
    check("lit_tgl", 0, out_a[31:0], 32'h00F0F0FF);

    // Readback
    bus(32'hE4, 32'h0, 4'h0, 0, 1);
    check("lit_rd_valid", 0, {31'h0, rvalid_a}, 32'h1);
    check("lit_rd_data", 0, rdata_a, 32'h12345678);
    bus(32'h84, 32'h1, 4'hF, 1, 1);
    check("lit_rdwr_old", 0, rdata_a, 32'h12345678);
    check("lit_rdwr_new", 0, out_a[63:32], 32'h1);
    bus(32'h88, 32'h0, 4'h0, 0, 1);
    check("lit_rd_oor_valid", 0, {31'h0, rvalid_a}, 32'h1);
    check("lit_rd_oor_data", 0, rdata_a, 32'h0);
    bus(32'h40, 32'h0, 4'h0, 0, 1);
    check("lit_rd_miss_valid", 0, {31'h0, rvalid_a}, 32'h0);
    bus(32'h87, 32'h0, 4'h0, 0, 1);
    check("lit_rd_lowbits", 0, rdata_a, 32'h1);
    idle();

    // Out-of-range writes and W=8 truncation
    bus(32'h98, 32'hFFFFFFFF, 4'hF, 1, 0);
    bus(32'h7C, 32'hFFFFFFFF, 4'hF, 1, 0);
    check("lit_oor_p0", 0, out_a[31:0], 32'h00F0F0FF);
    check("lit_oor_p1", 0, out_a[63:32], 32'h1);
    bus(32'h88, 32'hFFFFFF33, 4'hF, 1, 0);
    check("lit_w8_p2", 0, {24'h0, out_c[23:16]}, 32'h33);
    repeat (6) idle();
    check("lit_len0_p0", 0, {24'h0, out_c[7:0]}, 32'hFF);
    check("lit_len0_pact", 0, {29'h0, pa_c}, 32'h0);

    // Pulse: basic length
    bus(32'h84, 32'h1, 4'hF, 1, 0);
    check("lit_pulse_hi", 0, out_b[63:32], 32'h1);
    check("lit_pulse_act", 0, {30'h0, pa_b}, 32'h2);
    repeat (3) idle();
    check("lit_pulse_last", 0, out_b[63:32], 32'h1);
    idle();
    check("lit_pulse_lo", 0, out_b[63:32], 32'h0);
    check("lit_pulse_act_lo", 0, {30'h0, pa_b}, 32'h0);

    // Pulse: rewrite extends
    bus(32'h84, 32'h1, 4'hF, 1, 0);
    repeat (2) idle();
    bus(32'h84, 32'h2, 4'hF, 1, 0);
    idle();
    check("lit_ext_hold", 0, out_b[63:32], 32'h2);
    repeat (2) idle();
    check("lit_ext_last", 0, out_b[63:32], 32'h2);
    idle();
    check("lit_ext_lo", 0, out_b[63:32], 32'h0);

    // Pulse: write on the expiry edge wins; be=0 still reloads
    bus(32'h84, 32'h5, 4'hF, 1, 0);
    repeat (3) idle();
    bus(32'h84, 32'h6, 4'hF, 1, 0);
    check("lit_expwr", 0, out_b[63:32], 32'h6);
    repeat (2) idle();
    bus(32'hE4, 32'hFFFFFFFF, 4'h0, 1, 0);
    repeat (3) idle();
    check("lit_be0_hold", 0, out_b[63:32], 32'h6);
    idle();
    check("lit_be0_lo", 0, out_b[63:32], 32'h0);

    // Pulse: reset mid-pulse
    bus(32'h84, 32'h7, 4'hF, 1, 0);
    idle();
    clrn = 1'b0;
    #1;
    check("lit_rstpulse_p1", 0, out_b[63:32], 32'h5A);
    check("lit_rstpulse_act", 0, {30'h0, pa_b}, 32'h0);
    #1;
    clrn = 1'b1;
    repeat (6) idle();
    check("lit_after_rst", 0, out_b[63:32], 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_output_bank.md
Name: io_output_bank

Overview:
Memory-mapped bank of NPORTS output registers, W bits each, on the CPU IO bus at byte addresses 0x80-0xFF.
- Each port has four write aliases: DATA, SET, CLR and TGL.
- Byte enables qualify every write.
- Registered readback returns the current port value.
- Optional per-port pulse mode clears a port to 0 a fixed number of cycles after its last write.

Parameters:
NPORTS, 2, number of output ports (1..8)
W, 32, width of each port in bits (1..32); datas bits above W are ignored
RESET_VAL, 0, value loaded into every port on reset (low W bits used)
PULSE_MASK, 0, bit i = 1 puts port i in pulse mode
PULSE_LEN, 16, pulse duration in io_clk cycles (1..65535); 0 disables pulse mode for all ports

Ports:
io_clk  input  1  IO clock, rising edge
clrn  input  1  asynchronous active-low reset
addr  input  32  byte address; only addr[7:0] is decoded
datas  input  32  write data
be  input  4  byte enables; be[k] qualifies datas[8k+7:8k]
write_io_enable  input  1  write strobe, one write per cycle
read_io_enable  input  1  read strobe
out_ports  output  NPORTS*W  port i occupies bits [i*W+W-1 : i*W]
rdata  output  32  readback data, zero-extended
rvalid  output  1  rdata valid, one-cycle strobe
pulse_active  output  NPORTS  bit i = 1 while port i's pulse counter is nonzero

Behaviour:
Reset and clocking:
- Reset is decided: clrn is asynchronous and active-low; the clock is io_clk.
- On clrn=0: every port = RESET_VAL; all pulse counters = 0; pulse_active = 0; rdata = 0; rvalid = 0.
- Reset asserted mid-pulse aborts the pulse immediately.

Address decode:
- Block hit requires addr[7] = 1.
- op = addr[6:5]: 00 DATA (0x80+4i), 01 SET (0xA0+4i), 10 CLR (0xC0+4i), 11 TGL (0xE0+4i).
- Port index p = addr[4:2].
- Accesses with p >= NPORTS or addr[7] = 0 are ignored for writes; addr[1:0] is ignored.

Write, on a rising edge with write_io_enable=1 and a valid hit:
- bm = byte mask expanded from be, truncated to W bits; d = datas[W-1:0].
- DATA: port = (port & ~bm) | (d & bm).
- SET: port = port | (d & bm).
- CLR: port = port & ~(d & bm).
- TGL: port = port ^ (d & bm).
- Outputs update 1 cycle after the write edge (registered). be=0 leaves the value unchanged but still counts as a write for pulse reload.

Pulse mode (PULSE_MASK[p]=1 and PULSE_LEN>0), per-port 16-bit down-counter:
- Any write to the port loads the counter with PULSE_LEN.
- Each cycle the counter is nonzero it decrements.
- On the 1->0 transition the port is cleared to 0 (not RESET_VAL).
- The port therefore holds the written value for exactly PULSE_LEN cycles.
- A write in the expiry cycle wins: the new value is applied and the counter is reloaded; no clear occurs.
- pulse_active[i] = (counter_i != 0).
- Ports outside pulse mode have no counter behaviour; their pulse_active bit stays 0.

Read:
- read_io_enable=1 at edge t with addr[7]=1: rvalid=1 during the following cycle, rdata = value of port p (zero-extended) sampled before any same-edge write. All four op aliases read the same port.
- p >= NPORTS: rvalid=1, rdata=0.
- addr[7]=0 or read_io_enable=0: rvalid=0, rdata=0.
- Simultaneous read and write to the same port: read returns the old value; the write is applied.

Test Plan:
- Reset: NPORTS=2, RESET_VAL=0x5A. Hold clrn=0 -> out_ports=0x0000005A_0000005A, rvalid=0, pulse_active=0. Release and idle 5 cycles -> no change.
- Byte-enabled DATA write: write 0x80 datas=0xAABBCCDD be=4'b0101 over port0=0 -> port0=0x00BB00DD. Write 0x84 be=1111 datas=0x12345678 -> port1=0x12345678, port0 unchanged.
- SET/CLR/TGL: port0=0x0F0F0F0F.
  - Write 0xA0 datas=0xF0000000 -> 0xFF0F0F0F.
  - Write 0xC0 datas=0x0000000F -> 0xFF0F0F00.
  - Write 0xE0 datas=0xFFFFFFFF -> 0x00F0F0FF.
- Pulse: PULSE_MASK=2'b10, PULSE_LEN=4.
  - Write 0x84=0x1 at edge t -> port1=1 and pulse_active[1]=1 for cycles t+1..t+4, port1=0 from t+5.
  - Rewrite at edge t+3 -> the high period extends to 4 cycles after the rewrite.
  - clrn pulse at t+2 -> port1=RESET_VAL, pulse_active=0 immediately.
- Readback: port1=0x12345678, read 0xE4 -> next cycle rvalid=1, rdata=0x12345678. Same-edge write 0x84=0x1 with read of 0x84 -> rdata=0x12345678, then port1=1. Read 0x88 with NPORTS=2 -> rvalid=1, rdata=0. Read 0x40 -> rvalid=0.
- Out-of-range write: write 0x98 (p=6) and 0x7C -> all ports unchanged. With W=8, write datas=0xFFFFFF33 -> port=0x33.
